// File: rtl/isa_pkg.sv
// isa_pkg: opcode classes, instruction field positions and
// register-usage helpers shared by decode_stage and scoreboard.
package isa_pkg;

  typedef enum logic [3:0] {
    OP_NOP    = 4'h0,
    OP_ALU_LO = 4'h1,
    OP_ALU_HI = 4'h7,
    OP_LOAD   = 4'h8,
    OP_STORE  = 4'h9,
    OP_BR_LO  = 4'hA,
    OP_BR_HI  = 4'hB,
    OP_KMOV   = 4'hC,
    OP_RSV_LO = 4'hD
  } op_e;

  localparam int F_OP  = 28;
  localparam int F_RD  = 24;
  localparam int F_RS  = 20;
  localparam int F_RX  = 16;
  localparam int F_RK  = 12;
  localparam int F_IMM = 0;
  localparam int OP_W  = 4;
  localparam int IMM_W = 12;

  localparam logic [3:0] PC_REG = 4'd15;

  function automatic logic op_is_alu(logic [3:0] op);
    return op >= OP_ALU_LO && op <= OP_ALU_HI;
  endfunction

  function automatic logic op_is_br(logic [3:0] op);
    return op >= OP_BR_LO && op <= OP_BR_HI;
  endfunction

  function automatic logic op_reads_rs(logic [3:0] op);
    return op_is_alu(op) || op == OP_LOAD ||
           op == OP_STORE || op_is_br(op);
  endfunction

  function automatic logic op_reads_rx(logic [3:0] op);
    return op_is_alu(op) || op == OP_STORE ||
           op_is_br(op);
  endfunction

  function automatic logic op_reads_rk(logic [3:0] op);
    return op == OP_KMOV;
  endfunction

  function automatic logic op_writes_rd(logic [3:0] op);
    return op_is_alu(op) || op == OP_LOAD ||
           op == OP_KMOV;
  endfunction

  function automatic logic op_reserved(logic [3:0] op);
    return op >= OP_RSV_LO;
  endfunction

endpackage

// File: rtl/decode_stage_scoreboard.sv
// scoreboard: pending register-write vector with busy lookup.
// DECODE_WB_BYPASS_EN masks a same-cycle write-back from busy.
module scoreboard
  import isa_pkg::*;
#(
  parameter int dir = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_set_en,
  input  logic [dir-1:0] i_set_addr,
  input  logic           i_clr_en,
  input  logic [dir-1:0] i_clr_addr,
  input  logic [dir-1:0] i_rd_a,
  input  logic [dir-1:0] i_rd_b,
  input  logic [dir-1:0] i_rd_c,
  output logic           o_busy_a,
  output logic           o_busy_b,
  output logic           o_busy_c
);

  localparam int N = 1 << dir;

  logic [N-1:0] r_pend;
  logic [N-1:0] w_wb_mask;
  logic [N-1:0] w_live;

  always_comb begin
    w_wb_mask = '0;
`ifdef DECODE_WB_BYPASS_EN
    // bank writes on negedge, so this cycle's read already sees it
    if (i_clr_en) w_wb_mask[i_clr_addr] = 1'b1;
`endif
  end

  assign w_live   = r_pend & ~w_wb_mask;
  assign o_busy_a = w_live[i_rd_a];
  assign o_busy_b = w_live[i_rd_b];
  assign o_busy_c = w_live[i_rd_c];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
    end else begin
      if (i_clr_en) r_pend[i_clr_addr] <= 1'b0;
      if (i_set_en) r_pend[i_set_addr] <= 1'b1;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: splits instructions into bank addresses, holds one
// packet for execute, stalls on scoreboard hazards (DECODE_WB_BYPASS_EN).
module decode_stage
  import isa_pkg::*;
#(
  parameter int bus = 32,
  parameter int dir = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [bus-1:0]   in_instr,
  input  logic [bus-1:0]   in_pc,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OP_W-1:0]  out_op,
  output logic [dir-1:0]   RD,
  output logic [dir-1:0]   RS,
  output logic [dir-1:0]   RX,
  output logic [dir-1:0]   RK,
  output logic [IMM_W-1:0] out_imm,
  output logic [bus-1:0]   out_pc,
  output logic             RE,
  input  logic             wb_valid,
  input  logic [dir-1:0]   wb_rd,
  input  logic             flush,
  output logic             illegal
);

  localparam logic [dir-1:0] PC = dir'(PC_REG);

  logic [OP_W-1:0] w_op;
  logic [dir-1:0]  w_rs, w_rx, w_rk;
  logic            w_busy_rs, w_busy_rx, w_busy_rk;
  logic            w_held_wr, w_hazard;
  logic            w_accept, w_issue;

  logic             r_valid;
  logic [OP_W-1:0]  r_op;
  logic [dir-1:0]   r_rd, r_rs, r_rx, r_rk;
  logic [IMM_W-1:0] r_imm;
  logic [bus-1:0]   r_pc;

  assign w_op = in_instr[F_OP +: OP_W];
  assign w_rs = in_instr[F_RS +: dir];
  assign w_rx = in_instr[F_RX +: dir];
  assign w_rk = in_instr[F_RK +: dir];

  // held packet has not issued yet, so the scoreboard cannot see it
  assign w_held_wr = r_valid && op_writes_rd(r_op) && r_rd != PC;

  assign w_hazard =
    (op_reads_rs(w_op) &&
     (w_busy_rs || (w_held_wr && w_rs == r_rd))) ||
    (op_reads_rx(w_op) &&
     (w_busy_rx || (w_held_wr && w_rx == r_rd))) ||
    (op_reads_rk(w_op) &&
     (w_busy_rk || (w_held_wr && w_rk == r_rd)));

  assign in_ready = !rst && (!r_valid || out_ready) &&
                    !w_hazard && !flush;
  assign w_accept = in_valid && in_ready;
  assign w_issue  = !rst && r_valid && out_ready && !flush;

  assign RE        = w_issue;
  assign illegal   = w_issue && op_reserved(r_op);
  assign out_valid = r_valid;
  assign out_op    = r_op;
  assign RD        = r_rd;
  assign RS        = r_rs;
  assign RX        = r_rx;
  assign RK        = r_rk;
  assign out_imm   = r_imm;
  assign out_pc    = r_pc;

  scoreboard #(.dir(dir)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_set_en   (w_issue && w_held_wr),
    .i_set_addr (r_rd),
    .i_clr_en   (wb_valid),
    .i_clr_addr (wb_rd),
    .i_rd_a     (w_rs),
    .i_rd_b     (w_rx),
    .i_rd_c     (w_rk),
    .o_busy_a   (w_busy_rs),
    .o_busy_b   (w_busy_rx),
    .o_busy_c   (w_busy_rk)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_op    <= '0;
      r_rd    <= '0;
      r_rs    <= '0;
      r_rx    <= '0;
      r_rk    <= '0;
      r_imm   <= '0;
      r_pc    <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_op    <= w_op;
      r_rd    <= in_instr[F_RD +: dir];
      r_rs    <= w_rs;
      r_rx    <= w_rx;
      r_rk    <= w_rk;
      r_imm   <= in_instr[F_IMM +: IMM_W];
      r_pc    <= in_pc;
    end else if (flush || out_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and random stimulus checked every cycle
// against a packet/pending-set reference model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, wb_valid, flush;
  logic [31:0] in_instr, in_pc;
  logic        in_ready, out_valid, RE, illegal;
  logic [3:0]  out_op, RD, RS, RX, RK, wb_rd;
  logic [11:0] out_imm;
  logic [31:0] out_pc;

  int n_chk  = 0;
  int n_fail = 0;

  bit          m_pend[16];
  bit          m_hv;
  logic [31:0] m_hi, m_hp;

  always #5 clk = ~clk;

  decode_stage #(.bus(32), .dir(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_op    (out_op),
    .RD        (RD),
    .RS        (RS),
    .RX        (RX),
    .RK        (RK),
    .out_imm   (out_imm),
    .out_pc    (out_pc),
    .RE        (RE),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .flush     (flush),
    .illegal   (illegal)
  );

  function automatic bit f_rs(logic [3:0] op);
    return op >= 4'h1 && op <= 4'hB;
  endfunction

  function automatic bit f_rx(logic [3:0] op);
    return (op >= 4'h1 && op <= 4'h7) ||
           (op >= 4'h9 && op <= 4'hB);
  endfunction

  function automatic bit f_rk(logic [3:0] op);
    return op == 4'hC;
  endfunction

  function automatic bit f_wr(logic [3:0] op);
    return (op >= 4'h1 && op <= 4'h8) || op == 4'hC;
  endfunction

  function automatic bit busy(logic [3:0] r);
    bit p;
    p = m_pend[r];
`ifdef DECODE_WB_BYPASS_EN
    if (wb_valid && wb_rd == r) p = 1'b0;
`endif
    if (m_hv && f_wr(m_hi[31:28]) &&
        m_hi[27:24] == r && r != 4'd15) p = 1'b1;
    return p;
  endfunction

  function automatic logic [31:0] mk(
    int op, int rd, int rs, int rx, int rk, int imm);
    return {op[3:0], rd[3:0], rs[3:0], rx[3:0],
            rk[3:0], imm[11:0]};
  endfunction

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    logic [3:0] op;
    bit hz, rdy, iss;
    @(negedge clk);
    op  = in_instr[31:28];
    hz  = (f_rs(op) && busy(in_instr[23:20])) ||
          (f_rx(op) && busy(in_instr[19:16])) ||
          (f_rk(op) && busy(in_instr[15:12]));
    rdy = !rst && (!m_hv || out_ready) && !hz && !flush;
    iss = !rst && m_hv && out_ready && !flush;
    chk("in_ready", 64'(in_ready), 64'(rdy));
    chk("RE", 64'(RE), 64'(iss));
    chk("illegal", 64'(illegal),
        64'(iss && m_hi[31:28] >= 4'hD));
    chk("out_valid", 64'(out_valid), 64'(m_hv));
    chk("packet", {out_op, RD, RS, RX, RK, out_imm, out_pc},
        {m_hi, m_hp});
    if (rst) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_hv = 1'b0;
      m_hi = '0;
      m_hp = '0;
    end else begin
      if (wb_valid) m_pend[wb_rd] = 1'b0;
      if (iss && f_wr(m_hi[31:28]) && m_hi[27:24] != 4'd15)
        m_pend[m_hi[27:24]] = 1'b1;
      if (in_valid && rdy) begin
        m_hv = 1'b1;
        m_hi = in_instr;
        m_hp = in_pc;
      end else if (flush || out_ready) begin
        m_hv = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic put(logic [31:0] ins, logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
    in_instr = mk(1, 1, 2, 3, 0, 0); in_pc = '0;
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_hv = 1'b0; m_hi = '0; m_hp = '0;
    @(posedge clk); #1;
    put(mk(1, 1, 2, 3, 0, 5), 32'h100);
    cycle();
    rst = 1'b0; out_ready = 1'b1;
    // back-to-back independent ALU ops
    cycle();
    put(mk(2, 4, 5, 6, 0, 7), 32'h104);
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();
    // LOAD r3 then a reader of r3
    put(mk(8, 3, 0, 0, 0, 16), 32'h108);
    cycle();
    put(mk(3, 5, 3, 4, 0, 0), 32'h10C);
    repeat (3) cycle();
    wb_valid = 1'b1; wb_rd = 4'd3;
    cycle();
    wb_valid = 1'b0;
    cycle();
    in_valid = 1'b0;
    cycle();
    // hold a packet with out_ready low
    put(mk(1, 6, 8, 9, 0, 1), 32'h200);
    cycle();
    out_ready = 1'b0;
    put(mk(1, 10, 11, 12, 0, 2), 32'h204);
    repeat (3) cycle();
    out_ready = 1'b1;
    in_valid = 1'b0;
    cycle();
    cycle();
    // flush a held KMOV r7
    out_ready = 1'b0;
    put(mk(12, 7, 0, 0, 10, 0), 32'h300);
    cycle();
    flush = 1'b1; out_ready = 1'b1;
    put(mk(4, 8, 7, 7, 0, 0), 32'h304);
    cycle();
    flush = 1'b0;
    cycle();
    in_valid = 1'b0;
    cycle();
    // reserved opcode, then r15 write and read
    put(mk(14, 9, 0, 0, 0, 12'hABC), 32'h400);
    cycle();
    put(mk(1, 15, 8, 8, 0, 0), 32'h404);
    cycle();
    put(mk(1, 2, 15, 15, 0, 0), 32'h408);
    cycle();
    in_valid = 1'b0;
    cycle();
    // reset while stalled on r2
    put(mk(5, 13, 2, 1, 0, 0), 32'h500);
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    in_valid = 1'b0;
    cycle();
    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic [3:0] r1, r2, r3, r4;
      r1 = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 7));
      r2 = 4'($urandom_range(0, 7));
      r3 = 4'($urandom_range(0, 7));
      r4 = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 7));
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = {4'($urandom_range(0, 15)), r1, r2, r3, r4,
                   12'($urandom)};
      in_pc     = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      wb_valid  = ($urandom_range(0, 2) == 0);
      wb_rd     = 4'($urandom_range(0, 15));
      flush     = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage sitting directly upstream of the register bank. Accepts 32-bit instruction words from fetch over a valid/ready handshake and splits them into the register-address fields RD/RS/RX/RK. Drives the bank's RE strobe and forwards a decoded packet to execute. A 16-entry scoreboard of pending register writes stalls any instruction that would read a register whose write-back has not yet reached the bank.

## Interface
Parameters:
- `bus`, 32: instruction and PC width.
- `dir`, 4: register address width; 2**dir registers.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  fetch has an instruction.
- `in_instr`  in  bus  instruction word.
- `in_pc`  in  bus  PC of `in_instr`.
- `in_ready`  out  1  decode accepts this cycle.
- `out_valid`  out  1  decoded packet held.
- `out_ready`  in  1  execute accepts packet.
- `out_op`  out  4  opcode.
- `RD`, `RS`, `RX`, `RK`  out  dir  register addresses to the bank.
- `out_imm`  out  12  immediate, zero-extended by execute.
- `out_pc`  out  bus  PC of the packet.
- `RE`  out  1  register-bank read strobe.
- `wb_valid`  in  1  write-back completing this cycle (mirrors bank WE).
- `wb_rd`  in  dir  write-back destination.
- `flush`  in  1  discard the held packet (taken branch).
- `illegal`  out  1  one-cycle pulse when a reserved opcode issues.

## Operation
- Instruction fields:
  - `[31:28]` op; `[27:24]` RD; `[23:20]` RS; `[19:16]` RX; `[15:12]` RK; `[11:0]` imm.
- Opcode classes:
  - 0x0 NOP: no reads, no write.
  - 0x1–0x7 ALU: read RS, RX; write RD.
  - 0x8 LOAD: read RS; write RD.
  - 0x9 STORE: read RS, RX.
  - 0xA–0xB BRANCH: read RS, RX.
  - 0xC KMOV: read RK; write RD.
  - 0xD–0xF reserved: behave as NOP and pulse `illegal` at issue.
- Register 15 is the PC and is never scoreboarded. A write with RD=15 counts as no-write for hazard purposes.
- Hazard: any register the incoming instruction reads is
  - pending in the scoreboard, or
  - the write destination of the packet held in the output register.
- `in_ready` = !rst & (!out_valid | out_ready) & !hazard.
- Capture: on `in_valid & in_ready`, the output register loads the fields and `out_valid` is set. Otherwise `out_valid` clears when `out_ready` is high.
- Issue: `out_valid & out_ready`. `RE` = issue (combinational from registered `out_valid` and `out_ready`).
- Scoreboard:
  - Set bit RD at issue when the op writes.
  - Clear bit `wb_rd` on `wb_valid`.
  - Same register set and cleared in one cycle: set wins.
- `flush` clears `out_valid` and suppresses issue/RE that cycle. Scoreboard bits already set are kept.
- `flush` with `in_valid`: the capture is blocked (`in_ready` low).

## Timing
- Reset values:
  - `out_valid`, `RE`, `illegal`: 0.
  - All field outputs: 0.
  - Scoreboard: all 0.
  - `in_ready`: 0 during the reset cycle.
- Latency is one cycle from accept to `out_valid`. Bank operands appear on RSd/RXd/RKd one cycle after `RE`.
- Back-to-back throughput is 1 instruction/cycle with no hazards.
- Dependent instruction: stalls until the cycle `wb_valid` clears the bit. Without bypass it is accepted the following cycle.
- Reset mid-stall drops the held packet and all pending bits; the next instruction is accepted on the first cycle after reset.

## Configuration
- `DECODE_WB_BYPASS_EN`:
  - Defined: a `wb_valid`/`wb_rd` matching a pending source is masked in the same-cycle hazard check, so the dependent instruction is accepted in the write-back cycle. This is legal because the bank writes on negedge, before the next posedge read.
  - Undefined: hazard uses only the registered scoreboard, adding one stall cycle.

## Structure
- Shared package `isa_pkg`:
  - opcode enum and class constants;
  - field bit positions;
  - `PC_REG` = 15;
  - functions `op_reads_rs/rx/rk`, `op_writes_rd`.
- Sub-module `scoreboard`:
  - 16-bit pending vector with set/clear ports;
  - combinational `busy` lookup for three read addresses;
  - houses the bypass logic.

## Test plan
- Reset, then ALU r1←r2,r3 followed by ADD r4←r5,r6 with `out_ready`=1 → both issue in consecutive cycles; RE high 2 cycles; RD=1 then 4.
- LOAD r3, then ALU reading r3 → second instruction stalls (`in_ready`=0) until `wb_valid`, `wb_rd`=3. Accepted the next cycle, or the same cycle with `DECODE_WB_BYPASS_EN`.
- `out_ready`=0 for 3 cycles with packet held → `out_valid` stays 1, RE=0, `in_ready`=0, fields stable.
- `flush` while a KMOV to r7 is held → `out_valid`=0, no RE, r7 not set in the scoreboard.
- Opcode 0xE instruction → issues, `illegal` pulses once, no scoreboard change; write to r15 → no stall on a subsequent r15 read.
- Assert `rst` while stalled on r2 → next cycle scoreboard is 0 and a reader of r2 is accepted immediately.
